// File: rtl/mdc_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding and default sizes.
package mdc_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdc_reg.sv
// Operand register with a synchronous clear, a load port and a step-update port.
// The load port wins over the step-update port when both are asserted.
module mdc_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] data_l,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q
);

  // Clear, load a fresh operand, or take the next iteration value.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= data_l;
    else if (en) q <= data_i;
  end

endmodule

// File: rtl/mdc_p.sv
// Iterative GCD engine (IDLE -> CALC -> DONE).
// Default build uses the subtractive Euclid step. Defining MDC_BINARY_EN
// switches each step to the binary (Stein) algorithm; the ports are unchanged.
module mdc_p
  import mdc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [CNT_W-1:0] cycles
);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] exit_val;
  logic             accept;
  logic             operands_zero;
  logic             step;

  // A new request is only taken when no computation is running.
  assign accept        = start && (state != CALC);
  assign operands_zero = (a == '0) || (b == '0);
  assign step          = (state == CALC) && !operands_zero;
  assign busy          = (state == CALC);

  mdc_reg #(.WIDTH(WIDTH)) u_a (
    .clk    (clk),
    .rst    (rst),
    .ld     (accept),
    .en     (step),
    .data_l (i_a),
    .data_i (a_next),
    .q      (a)
  );

  mdc_reg #(.WIDTH(WIDTH)) u_b (
    .clk    (clk),
    .rst    (rst),
    .ld     (accept),
    .en     (step),
    .data_l (i_b),
    .data_i (b_next),
    .q      (b)
  );

`ifdef MDC_BINARY_EN
  localparam int KW = $clog2(WIDTH) + 1;

  logic [KW-1:0] k;
  logic          k_inc;

  // Stein step: strip common factors of two into k, strip lone factors of
  // two, otherwise subtract the smaller odd operand from the larger.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    a_next = a;
    b_next = b;
    k_inc  = 1'b0;
    if (!a[0] && !b[0]) begin
      a_next = a >> 1;
      b_next = b >> 1;
      k_inc  = 1'b1;
    end else if (!a[0]) begin
      a_next = a >> 1;
    end else if (!b[0]) begin
      b_next = b >> 1;
    end else if (a >= b) begin
      a_next = a - b;
    end else begin
      b_next = b - a;
    end
  end

  // Count the shared powers of two removed so far; restored on exit.
  always_ff @(posedge clk) begin
    if (rst)                k <= '0;
    else if (accept)        k <= '0;
    else if (step && k_inc) k <= k + KW'(1);
  end

  assign exit_val = (a | b) << k;
`else
  // Subtractive Euclid step: the larger operand loses the smaller, so neither
  // operand can underflow.
  always_comb begin
    a_next = a;
    b_next = b;
    if (a >= b) a_next = a - b;
    else        b_next = b - a;
  end

  assign exit_val = a | b;
`endif

  // Control FSM: accept requests, count steps (saturating), publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      res    <= '0;
      cycles <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= CALC;
            cycles <= '0;
            done   <= 1'b0;
          end
        end
        CALC: begin
          if (operands_zero) begin
            res   <= exit_val;
            done  <= 1'b1;
            state <= DONE;
          end else if (cycles != {CNT_W{1'b1}}) begin
            cycles <= cycles + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
